// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for one shared downstream bus port.
// Grant is locked from selection through handshake to completion.
module bus_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  req_ack,
  output logic [N-1:0]  req_done,
  output logic          bus_valid,
  input  logic          bus_ready,
  input  logic          bus_done,
  output logic [IW-1:0] grant_idx,
  output logic [N-1:0]  grant_oh,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          any;
  logic          hs;
  logic          fin;

  // First set request at or after ptr; IW-bit add wraps mod N
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + IW'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  assign hs       = (state == REQ) && bus_ready;
  assign fin      = (state == WAIT) && bus_done;
  assign req_ack  = grant_oh & {N{hs}};
  assign req_done = grant_oh & {N{fin}};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      grant_oh  <= '0;
      bus_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_idx <= sel;
            grant_oh  <= N'(1) << sel;
            bus_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus_done) begin
            grant_oh <= '0;
            ptr      <= grant_idx + IW'(1);
            state    <= IDLE;
          end
        end
        default: begin
          bus_valid <= 1'b0;
          grant_oh  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized and directed bench for bus_rr_arbiter.
// Outputs compared each cycle to a transaction-level model.
module tb_bus_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  req_done;
  logic          bus_valid;
  logic          bus_ready;
  logic          bus_done;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  grant_oh;
  logic          busy;

  bus_rr_arbiter #(.N(N), .IW(IW)) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .req_ack(req_ack),
    .req_done(req_done),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_done(bus_done),
    .grant_idx(grant_idx),
    .grant_oh(grant_oh),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: owner is -1-free; busy/handshaken describe the transaction
  bit m_busy;
  bit m_hs;
  int m_owner;
  int m_ptr;
  int acks[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_hs    = 0;
    m_owner = 0;
    m_ptr   = 0;
  endtask

  task automatic step(input logic [N-1:0] r, input logic rdy,
                      input logic dn, input logic rn);
    logic [N-1:0] e_oh;
    @(negedge clk);
    req       = r;
    bus_ready = rdy;
    bus_done  = dn;
    resetn    = rn;
    #1;
    e_oh = m_busy ? oh(m_owner) : '0;
    chk("busy", busy, m_busy);
    chk("bus_valid", bus_valid, m_busy && !m_hs);
    chk("grant_idx", grant_idx, m_owner);
    chk("grant_oh", grant_oh, e_oh);
    chk("req_ack", req_ack,
        (m_busy && !m_hs && rdy) ? e_oh : '0);
    chk("req_done", req_done,
        (m_busy && m_hs && dn) ? e_oh : '0);
    if (req_ack != '0) acks.push_back(int'(grant_idx));
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_busy && r[j]) begin
          m_busy  = 1;
          m_hs    = 0;
          m_owner = j;
        end
      end
    end else if (!m_hs) begin
      if (rdy) m_hs = 1;
    end else if (dn) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn    = 1'b0;
    req       = '0;
    bus_ready = 1'b0;
    bus_done  = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state and single request
    step('0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

    // all requesting: order 0,1,2,3,0
    do_reset();
    acks.delete();
    repeat (15) step(4'b1111, 1'b1, 1'b1, 1'b1);
    chk("rr_count", acks.size(), 5);
    if (acks.size() >= 5) begin
      chk("rr0", acks[0], 0);
      chk("rr1", acks[1], 1);
      chk("rr2", acks[2], 2);
      chk("rr3", acks[3], 3);
      chk("rr4", acks[4], 0);
    end

    // wrap from ptr=3
    do_reset();
    repeat (3) step(4'b0100, 1'b1, 1'b1, 1'b1);
    acks.delete();
    repeat (6) step(4'b1001, 1'b1, 1'b1, 1'b1);
    chk("wrap_count", acks.size(), 2);
    if (acks.size() >= 2) begin
      chk("wrap0", acks[0], 3);
      chk("wrap1", acks[1], 0);
    end

    // ready stalls while req changes; done in REQ ignored
    do_reset();
    step(4'b1000, 1'b0, 1'b0, 1'b1);
    repeat (5) step(4'b0001, 1'b0, 1'b1, 1'b1);
    chk("stall_idx", grant_idx, 3);
    step(4'b0001, 1'b1, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1, 1'b1);

    // reset during WAIT, later done ignored, ptr back to 0
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0010, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b1);
    acks.delete();
    repeat (3) step(4'b1111, 1'b1, 1'b1, 1'b1);
    chk("post_rst", acks.size() > 0 ? acks[0] : -1, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(N'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
